// File: rtl/fifo_main_buffer_if.sv
// Handshake and status bundle between the main ingress FIFO and its neighbours.
// The master side is the source/arbiter pair; the slave side is the FIFO.
interface fifo_main_buffer_if #(
  parameter int DATA_WIDTH = 6
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  almost_full;
  logic                  almost_empty;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, fifo_empty, fifo_full, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_main_buffer.sv
// Main ingress FIFO: buffers source words, returns popped words one cycle
// after the pop edge, and exposes occupancy flags with programmable thresholds.
module fifo_main_buffer #(
  parameter int DATA_WIDTH      = 6,
  parameter int ADDR_WIDTH      = 3,
  parameter int UMBRAL_ALTO_DEF = 6,
  parameter int UMBRAL_BAJO_DEF = 1
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                init,
  input  logic [ADDR_WIDTH:0] umbral_alto,
  input  logic [ADDR_WIDTH:0] umbral_bajo,
  fifo_main_buffer_if.slave   bus,
  output logic                error,
  output logic [ADDR_WIDTH:0] count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ALTO_RST   = (ADDR_WIDTH + 1)'(UMBRAL_ALTO_DEF);
  localparam logic [ADDR_WIDTH:0] BAJO_RST   = (ADDR_WIDTH + 1)'(UMBRAL_BAJO_DEF);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   alto_q;
  logic [ADDR_WIDTH:0]   bajo_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;

  logic is_empty;
  logic is_full;
  logic pop_ok;
  logic push_ok;
  logic fault;

  // Accept decisions; a pop on an empty FIFO never reads through a same-cycle push.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == FULL_COUNT);
    pop_ok   = bus.pop && !is_empty;
    push_ok  = bus.push && (!is_full || pop_ok);
    fault    = (bus.push && !push_ok) || (bus.pop && is_empty && !bus.push);
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (!init && push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  // Pointers, occupancy, read port, sticky error and threshold registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error   <= 1'b0;
      alto_q  <= ALTO_RST;
      bajo_q  <= BAJO_RST;
    end else if (init) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      error   <= 1'b0;
      alto_q  <= umbral_alto;
      bajo_q  <= umbral_bajo;
    end else begin
      valid_q <= pop_ok;
      if (pop_ok) begin
        data_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count <= count - 1'b1;
      end
      if (fault) begin
        error <= 1'b1;
      end
    end
  end

  assign bus.data_out     = data_q;
  assign bus.valid_out    = valid_q;
  assign bus.fifo_empty   = is_empty;
  assign bus.fifo_full    = is_full;
  assign bus.almost_full  = (count >= alto_q);
  assign bus.almost_empty = (count <= bajo_q);

endmodule

// File: tb/tb_fifo_main_buffer.sv
// Directed bench for the main ingress FIFO with hand-computed expectations.
module tb_fifo_main_buffer;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       init = 1'b0;
  logic [3:0] umbral_alto = 4'd6;
  logic [3:0] umbral_bajo = 4'd1;
  logic       error;
  logic [3:0] count;

  int unsigned total = 0;
  int unsigned bad = 0;

  fifo_main_buffer_if #(.DATA_WIDTH(6)) bus ();

  fifo_main_buffer #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(3),
    .UMBRAL_ALTO_DEF(6),
    .UMBRAL_BAJO_DEF(1)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .init(init),
    .umbral_alto(umbral_alto),
    .umbral_bajo(umbral_bajo),
    .bus(bus),
    .error(error),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request pattern; returns #1 after the edge.
  task automatic cyc(input logic p, input logic [5:0] d, input logic q);
    bus.push = p;
    bus.data_in = d;
    bus.pop = q;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
  endtask

  task automatic do_init(input logic [3:0] alto, input logic [3:0] bajo);
    init = 1'b1;
    umbral_alto = alto;
    umbral_bajo = bajo;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;

    // 1: reset then idle
    repeat (2) @(posedge clk);
    #1 reset_L = 1'b1;
    cyc(1'b0, 6'h00, 1'b0);
    check("rst_empty", 32'(bus.fifo_empty), 32'd1);
    check("rst_aempty", 32'(bus.almost_empty), 32'd1);
    check("rst_full", 32'(bus.fifo_full), 32'd0);
    check("rst_afull", 32'(bus.almost_full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_dout", 32'(bus.data_out), 32'd0);

    // umbral_alto=0 forces almost_full even when empty
    do_init(4'd0, 4'd1);
    check("alto0_afull", 32'(bus.almost_full), 32'd1);
    do_init(4'd6, 4'd1);
    check("alto6_afull", 32'(bus.almost_full), 32'd0);

    // 2: fill with 1..8, then overflow
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 6'(i), 1'b0);
      check("fill_count", 32'(count), 32'(i));
      check("fill_afull", 32'(bus.almost_full), (i >= 6) ? 32'd1 : 32'd0);
      check("fill_full", 32'(bus.fifo_full), (i == 8) ? 32'd1 : 32'd0);
      check("fill_aempty", 32'(bus.almost_empty), (i <= 1) ? 32'd1 : 32'd0);
    end
    cyc(1'b1, 6'h3F, 1'b0);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_count", 32'(count), 32'd8);

    // 3: drain, oldest first; 0x3F must not appear
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("drain_dout", 32'(bus.data_out), 32'(i));
      check("drain_valid", 32'(bus.valid_out), 32'd1);
      check("drain_count", 32'(count), 32'(8 - i));
    end
    check("drain_empty", 32'(bus.fifo_empty), 32'd1);
    cyc(1'b0, 6'h00, 1'b0);
    check("idle_valid", 32'(bus.valid_out), 32'd0);
    check("idle_dout_hold", 32'(bus.data_out), 32'h08);
    do_init(4'd6, 4'd1);
    check("init_clr_error", 32'(error), 32'd0);
    check("init_dout_hold", 32'(bus.data_out), 32'h08);
    cyc(1'b0, 6'h00, 1'b1);
    check("udf_valid", 32'(bus.valid_out), 32'd0);
    check("udf_error", 32'(error), 32'd1);
    check("udf_count", 32'(count), 32'd0);
    do_init(4'd6, 4'd1);

    // 4: pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'(8'h10 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("pre_dout", 32'(bus.data_out), 32'(8'h10 + i));
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 6'(8'h2A + i), 1'b0);
    check("wrap_count5", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("wrap_dout", 32'(bus.data_out), 32'(8'h2A + i));
      check("wrap_valid", 32'(bus.valid_out), 32'd1);
    end
    check("wrap_count0", 32'(count), 32'd0);
    check("wrap_error", 32'(error), 32'd0);

    // 5a: push+pop on empty
    cyc(1'b1, 6'h15, 1'b1);
    check("pp_empty_count", 32'(count), 32'd1);
    check("pp_empty_valid", 32'(bus.valid_out), 32'd0);
    check("pp_empty_error", 32'(error), 32'd0);
    cyc(1'b0, 6'h00, 1'b1);
    check("pp_empty_dout", 32'(bus.data_out), 32'h15);

    // 5b: push+pop on full
    for (int i = 0; i < 8; i++) cyc(1'b1, 6'(8'h20 + i), 1'b0);
    cyc(1'b1, 6'h30, 1'b1);
    check("pp_full_count", 32'(count), 32'd8);
    check("pp_full_full", 32'(bus.fifo_full), 32'd1);
    check("pp_full_dout", 32'(bus.data_out), 32'h20);
    check("pp_full_valid", 32'(bus.valid_out), 32'd1);
    check("pp_full_error", 32'(error), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 6'h00, 1'b1);
      check("pp_full_drain", 32'(bus.data_out), (i == 8) ? 32'h30 : 32'(8'h20 + i));
    end
    check("pp_full_end", 32'(count), 32'd0);

    // 6: init while occupied with error set
    cyc(1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 6'(8'h01 + i), 1'b0);
    check("pre_init_count", 32'(count), 32'd4);
    check("pre_init_error", 32'(error), 32'd1);
    do_init(4'd3, 4'd0);
    check("init_count", 32'(count), 32'd0);
    check("init_error", 32'(error), 32'd0);
    check("init_aempty", 32'(bus.almost_empty), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 6'(8'h38 + i), 1'b0);
      check("thr_afull", 32'(bus.almost_full), (i >= 3) ? 32'd1 : 32'd0);
      check("thr_aempty", 32'(bus.almost_empty), 32'd0);
    end

    // asynchronous reset mid-stream with a pop in flight
    cyc(1'b0, 6'h00, 1'b1);
    check("mid_valid", 32'(bus.valid_out), 32'd1);
    check("mid_dout", 32'(bus.data_out), 32'h39);
    bus.pop = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    check("arst_valid", 32'(bus.valid_out), 32'd0);
    check("arst_dout", 32'(bus.data_out), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(bus.fifo_empty), 32'd1);
    check("arst_aempty", 32'(bus.almost_empty), 32'd1);
    check("arst_afull", 32'(bus.almost_full), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    bus.pop = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_main_buffer.md
Name: fifo_main_buffer

Overview:
- Main ingress FIFO of the flow-control datapath.
- Sits directly upstream of the input-flow arbiter: supplies `fifo_empty_main` and receives the arbiter's `pop_main_cond` as its `pop`.
- Buffers words from the source, returns popped words with one cycle of registered latency, and exposes occupancy-threshold flags.
- `almost_full` is the pause flag toward the source.

Parameters:
- DATA_WIDTH, 6, width of each stored word
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (8 words)
- UMBRAL_ALTO_DEF, 6, reset value of the high (almost-full) threshold
- UMBRAL_BAJO_DEF, 1, reset value of the low (almost-empty) threshold

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_L  input  1  asynchronous, active-low reset
- init  input  1  synchronous soft clear plus threshold load
- umbral_alto  input  ADDR_WIDTH+1  high threshold, loaded while init=1
- umbral_bajo  input  ADDR_WIDTH+1  low threshold, loaded while init=1
- push  input  1  write request
- data_in  input  DATA_WIDTH  write data
- pop  input  1  read request (driven by pop_main_cond)
- data_out  output  DATA_WIDTH  registered read data
- valid_out  output  1  data_out holds a newly popped word this cycle
- fifo_empty  output  1  count==0
- fifo_full  output  1  count==DEPTH
- almost_full  output  1  count>=umbral_alto register (pause to source)
- almost_empty  output  1  count<=umbral_bajo register
- error  output  1  sticky overflow/underflow flag
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- **Reset (reset_L=0, asynchronous, immediate):**
  - wr_ptr, rd_ptr, count, data_out, valid_out, error = 0.
  - Threshold registers = UMBRAL_ALTO_DEF / UMBRAL_BAJO_DEF.
  - fifo_empty=1, almost_empty=1, fifo_full=0, almost_full=0.
  - Memory contents are don't-care.
- **init=1 (synchronous, takes priority over push/pop):**
  - Pointers, count, error, valid_out are cleared.
  - Threshold registers load umbral_alto/umbral_bajo.
  - push and pop are ignored that cycle.
  - data_out holds its value.
- **Accepted pop:** pop=1 and count!=0.
  - Next edge: data_out <= mem[rd_ptr], valid_out <= 1, rd_ptr increments.
  - Read latency is exactly one cycle after the pop edge.
- **Not-accepted pop or no pop:** valid_out <= 0, data_out holds.
- **Accepted push:**
  - Condition: push=1 and either count!=DEPTH, or a pop is accepted in the same cycle.
  - Effect: mem[wr_ptr] <= data_in, wr_ptr increments.
- **Pointer wrap:** pointers wrap modulo DEPTH naturally (ADDR_WIDTH bits); no special case.
- **count:** +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- **Simultaneous push and pop:**
  - When empty: the push is accepted and the pop is ignored (no read-through). valid_out=0, error is not set, count becomes 1.
  - When full: both are accepted, count stays at DEPTH, fifo_full stays 1.
- **Error conditions (error <= 1, sticky until reset_L or init):**
  - push while full with no accepted pop: the word is dropped, state is unchanged.
  - pop while empty with no push.
- **Flags:**
  - All flags are combinational from the registered count and threshold registers, so they update in the cycle after the accepted operation.
  - Flags have no other registered delay.
- **Threshold rules:**
  - Threshold values outside 0..DEPTH are used as-is, with unsigned compare.
  - umbral_alto=0 forces almost_full=1.
- **Reset mid-operation:** an asserted reset_L aborts any in-flight pop. valid_out drops immediately.

Test Plan:
1. Reset then idle → fifo_empty=1, almost_empty=1, count=0, valid_out=0, error=0, data_out=0.
2. Push 0x01..0x08 on consecutive cycles → count steps 1..8; almost_full rises when count=6; fifo_full=1 at 8. A 9th push of 0x3F → error=1, count=8, word dropped.
3. Pop ×8 from the full state → data_out sequence 0x01..0x08, each one cycle after its pop with valid_out=1. fifo_empty=1 after the last pop. A 9th pop → valid_out=0, error=1.
4. Pointer wrap: push 5, pop 5, then push 0x2A..0x2E and pop them → outputs 0x2A..0x2E in order, count returns to 0.
5. Simultaneous events:
   - push+pop on empty → count=1, valid_out=0, error=0.
   - push+pop on full → count=8, popped word is the oldest, new word is stored last.
6. init with umbral_alto=3, umbral_bajo=0 while count=4 and error=1 → count=0, error=0. Then 3 pushes → almost_full=1 at count=3; almost_empty=0 once count≥1. Finally, drive reset_L low mid-stream → all outputs return to reset values immediately.
